// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell plus a borrow flip-flop; operands loaded and result presented in parallel.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf
);

    localparam logic [1:0]    S_IDLE = 2'd0;
    localparam logic [1:0]    S_RUN  = 2'd1;
    localparam logic [1:0]    S_DONE = 2'd2;
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

    function automatic logic fs_diff(input logic a, input logic b, input logic bi);
        return a ^ b ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic bi);
        return (~a & b) | (~(a ^ b) & bi);
    endfunction

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d;
    logic [WIDTH-1:0] shb_q, shb_d;
    // Only WIDTH-1 earlier bits are stored; the final bit joins them on the completion edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             amsb_q, amsb_d;
    logic             bmsb_q, bmsb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_d_s;
    logic             bit_bo_s;
    logic [WIDTH-1:0] res_full_s;

    // Full-subtractor cell and next-state logic for the controller and datapath.
    always_comb begin
        state_d    = state_q;
        sha_d      = sha_q;
        shb_d      = shb_q;
        res_d      = res_q;
        borrow_d   = borrow_q;
        cnt_d      = cnt_q;
        amsb_d     = amsb_q;
        bmsb_d     = bmsb_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bit_d_s    = fs_diff(sha_q[0], shb_q[0], borrow_q);
        bit_bo_s   = fs_borrow(sha_q[0], shb_q[0], borrow_q);
        res_full_s = {bit_d_s, res_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d  = S_RUN;
                    sha_d    = A;
                    shb_d    = B;
                    borrow_d = Bin;
                    amsb_d   = A[WIDTH-1];
                    bmsb_d   = B[WIDTH-1];
                    cnt_d    = {CW{1'b0}};
                    busy_d   = 1'b1;
                end else begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                end
            end
            S_RUN: begin
                sha_d    = {1'b0, sha_q[WIDTH-1:1]};
                shb_d    = {1'b0, shb_q[WIDTH-1:1]};
                res_d    = res_full_s[WIDTH-1:1];
                borrow_d = bit_bo_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    diff_d  = res_full_s;
                    bout_d  = bit_bo_s;
                    ovf_d   = (amsb_q != bmsb_q) && (bit_d_s != amsb_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            sha_q    <= {WIDTH{1'b0}};
            shb_q    <= {WIDTH{1'b0}};
            res_q    <= {(WIDTH-1){1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sha_q    <= sha_d;
            shb_q    <= shb_d;
            res_q    <= res_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign Diff = diff_q;
    assign Bout = bout_q;
    assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed plan plus randomized operations
// checked against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         Ovf;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_diff = '0;
    logic         exp_bout = 1'b0;
    logic         exp_ovf  = 1'b0;

    serial_subtractor #(.WIDTH(W), .CW(4)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .A(A), .B(B), .Bin(Bin),
        .Busy(Busy), .Done(Done), .Diff(Diff), .Bout(Bout), .Ovf(Ovf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int ua;
        int ub;
        int s;
        ua = int'(a);
        ub = int'(b);
        s  = int'($signed(a)) - int'($signed(b)) - int'(bi);
        d  = W'((ua - ub - int'(bi)) & 255);
        bo = (ua < ub + int'(bi));
        ov = (s > 127) || (s < -128);
    endfunction

    // Called at a negedge: present operands with Start, then follow the op through Done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                         input bit cont, input int pulse_at);
        logic [W-1:0] ed;
        logic         eb;
        logic         eo;
        A = a; B = b; Bin = bi; Start = 1'b1;
        model(a, b, bi, ed, eb, eo);
        for (int i = 1; i <= W; i++) begin
            @(negedge CLK);
            chk("run_busy", 32'(Busy), 32'd1);
            chk("run_done", 32'(Done), 32'd0);
            chk("run_diff_hold", 32'(Diff), 32'(exp_diff));
            chk("run_bout_hold", 32'(Bout), 32'(exp_bout));
            A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
            if (!cont) Start = (i == pulse_at);
            if (i == pulse_at) begin A = 8'hFF; B = 8'h00; end
        end
        @(negedge CLK);
        chk("done_pulse", 32'(Done), 32'd1);
        chk("done_busy", 32'(Busy), 32'd0);
        chk("diff", 32'(Diff), 32'(ed));
        chk("bout", 32'(Bout), 32'(eb));
        chk("ovf", 32'(Ovf), 32'(eo));
        exp_diff = ed; exp_bout = eb; exp_ovf = eo;
    endtask

    initial begin
        RST = 1'b1; Start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_diff", 32'(Diff), 32'd0);
        chk("rst_bout", 32'(Bout), 32'd0);
        chk("rst_ovf", 32'(Ovf), 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 0);
        chk("t1_const", 32'(Diff), 32'h1E);
        do_op(8'h00, 8'h01, 1'b0, 1'b0, 0);
        chk("t2a_const", 32'(Diff), 32'hFF);
        chk("t2a_bout", 32'(Bout), 32'd1);
        do_op(8'h10, 8'h0F, 1'b1, 1'b0, 0);
        chk("t2b_const", 32'(Diff), 32'h00);
        do_op(8'h80, 8'h01, 1'b0, 1'b0, 0);
        chk("t3a_ovf", 32'(Ovf), 32'd1);
        chk("t3a_const", 32'(Diff), 32'h7F);
        do_op(8'h7F, 8'hFF, 1'b0, 1'b0, 0);
        chk("t3b_const", 32'(Diff), 32'h80);
        chk("t3b_ovf", 32'(Ovf), 32'd1);
        do_op(8'h33, 8'h33, 1'b1, 1'b0, 0);
        chk("eq_bin_ones", 32'(Diff), 32'hFF);
        do_op(8'h00, 8'hFF, 1'b1, 1'b0, 0);
        chk("zero_minus_ones", 32'(Diff), 32'h00);
        chk("zero_minus_ones_bout", 32'(Bout), 32'd1);

        // Start pulsed mid-run is ignored; module returns to IDLE.
        do_op(8'h5A, 8'h3C, 1'b0, 1'b0, 3);
        chk("t4_const", 32'(Diff), 32'h1E);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t4_idle_done", 32'(Done), 32'd0);
            chk("t4_idle_busy", 32'(Busy), 32'd0);
        end

        // Start held high: three back-to-back operations.
        do_op(8'h12, 8'h34, 1'b0, 1'b1, 0);
        do_op(8'hC8, 8'h07, 1'b1, 1'b1, 0);
        do_op(8'h01, 8'h80, 1'b0, 1'b0, 0);

        // Reset during RUN aborts without a Done pulse.
        @(negedge CLK);
        A = 8'h99; B = 8'h11; Bin = 1'b0; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t6_busy", 32'(Busy), 32'd0);
        chk("t6_done", 32'(Done), 32'd0);
        chk("t6_diff", 32'(Diff), 32'd0);
        chk("t6_bout", 32'(Bout), 32'd0);
        chk("t6_ovf", 32'(Ovf), 32'd0);
        exp_diff = '0; exp_bout = 1'b0; exp_ovf = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("t6_no_done", 32'(Done), 32'd0);
            chk("t6_no_busy", 32'(Busy), 32'd0);
        end
        do_op(8'hA5, 8'h5A, 1'b1, 1'b0, 0);

        for (int n = 0; n < 25; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom),
                  (n < 24) ? bit'($urandom_range(1, 0)) : 1'b0,
                  int'($urandom_range(7, 0)));
        end
        @(negedge CLK);
        chk("end_idle_done", 32'(Done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
